updown_step_counter: RTL and testbench
======================================

# updown_step_counter

Parametrised up/down counter with programmable runtime limit, variable step, synchronous load/clear and selectable wrap or saturate behaviour. It generalises the fixed-max, step-of-one counter used across the UART/ALU datapath for baud dividers, byte indices and timeouts. It exposes both the registered count and the combinational next-count, plus boundary flags and a registered wrap/clamp event pulse.

## Interface
- width_p, 8, counter width in bits (≥2)
- reset_val_p, '0, count value loaded by reset_i (width_p bits)
- saturate_p, 0, 0 = wrap at the limits, 1 = saturate at the limits

- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous clear to 0
- load_i  in  1  synchronous load of load_val_i
- load_val_i  in  width_p  value for load_i
- up_i  in  1  count up by step
- down_i  in  1  count down by step
- step_i  in  width_p  increment/decrement magnitude
- limit_i  in  width_p  inclusive maximum count; range is 0..limit_i
- count_o  out  width_p  registered count
- count_n_o  out  width_p  combinational value count_o takes at next edge
- at_max_o  out  1  count_o == limit_i (combinational)
- at_zero_o  out  1  count_o == 0 (combinational)
- event_o  out  1  registered one-cycle pulse: previous update wrapped (saturate_p=0) or clamped (saturate_p=1)

## Operation
- Priority per cycle: reset_i > clear_i > load_i > (up_i XOR down_i) > hold.
- up_i and down_i both high: hold, no event.
- clear_i: next = 0, event_o next = 0.
- load_i: next = min(load_val_i, limit_i); event_o next = 0.
- Effective step s = min(step_i, limit_i). step_i = 0 with up/down: hold, no event.
- Out-of-range guard: if count_o > limit_i when up or down is active, next = 0 (wrap mode) or limit_i (saturate mode), event_o next = 1; step ignored.
- Up, wrap mode: sum = count_o + s computed in width_p+1 bits; sum > limit_i → next = sum − (limit_i + 1), event; else next = sum.
- Down, wrap mode: s > count_o → next = count_o + (limit_i + 1) − s (width_p+1 bits), event; else next = count_o − s.
- Up, saturate mode: sum > limit_i → next = limit_i, event; else sum. Already at limit_i with s>0 → stays, event asserted.
- Down, saturate mode: s > count_o → next = 0, event; else count_o − s. At 0 with s>0 → stays 0, event.
- limit_i = all-ones: limit_i + 1 handled in width_p+1 bits, no truncation.
- count_n_o equals the next-state value above in every case, including reset_val_p while reset_i is high.

## Timing
- Reset (async assert): count_o = reset_val_p, event_o = 0 immediately; count_n_o = reset_val_p. Deassertion is sampled at the next clk_i edge; first update happens on the first edge with reset_i low.
- Count latency: 1 cycle; count_o at edge N+1 = count_n_o in cycle N.
- event_o: high exactly the cycle after the wrapping/clamping update, low otherwise; back-to-back wraps give consecutive high cycles.
- at_max_o / at_zero_o follow count_o and limit_i combinationally, with no added latency; both high when limit_i = 0 and count_o = 0.
- limit_i and step_i are sampled only in the cycle of use; changes take effect immediately.

## Test plan
- width_p=4, wrap, limit 9, step 3, up held from 0: count 0,3,6,9,2,5; event_o high the cycle after 9→2 only.
- Wrap, limit 9, step 4, down from 2: next 8 (2+10−4); event_o pulses; at_zero_o never set.
- saturate_p=1, limit 12, step 5, up from 10: 10→12, event pulse; further up stays 12, event_o held high; down step 5 → 7, event low.
- Priority: clear_i, load_i (val 7) and up_i all high → count 0; load_i with load_val_i 15, limit 9 → 9; up_i & down_i together → hold.
- Limit lowered to 3 while count 8, up asserted: wrap → 0, saturate → 3, event_o pulses; step_i 6 > limit 3 in wrap mode from 1 → 1+3−4 = 0.
- Assert reset_i asynchronously mid-count (count 5, reset_val_p 2): count_o 2 immediately, event_o 0; width_p=8, limit 255, step 1 from 255 wraps to 0.

Source files
------------

// File: rtl/updown_step_counter_if.sv
// rtl/updown_step_counter_if.sv - control/status bundle for updown_step_counter
interface updown_step_counter_if #(
   parameter int width_p = 8
);
   logic               clear_i;
   logic               load_i;
   logic [width_p-1:0] load_val_i;
   logic               up_i;
   logic               down_i;
   logic [width_p-1:0] step_i;
   logic [width_p-1:0] limit_i;
   logic [width_p-1:0] count_o;
   logic [width_p-1:0] count_n_o;
   logic               at_max_o;
   logic               at_zero_o;
   logic               event_o;

   modport master (
      output clear_i, load_i, load_val_i, up_i, down_i, step_i, limit_i,
      input  count_o, count_n_o, at_max_o, at_zero_o, event_o
   );

   modport slave (
      input  clear_i, load_i, load_val_i, up_i, down_i, step_i, limit_i,
      output count_o, count_n_o, at_max_o, at_zero_o, event_o
   );
endinterface

// File: rtl/updown_step_counter.sv
// rtl/updown_step_counter.sv - up/down counter with runtime limit, variable step, wrap or saturate
module updown_step_counter #(
   parameter int                 width_p     = 8,
   parameter logic [width_p-1:0] reset_val_p = '0,
   parameter bit                 saturate_p  = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   updown_step_counter_if.slave   bus
);

   logic [width_p-1:0] r_count;
   logic               r_event;

   logic [width_p-1:0] w_step_eff;
   logic [width_p-1:0] w_load_eff;
   logic [width_p:0]   w_sum;
   logic [width_p-1:0] w_up_wrap;
   logic [width_p-1:0] w_dn_wrap;
   logic               w_out_of_range;
   logic               w_move;
   logic [width_p-1:0] w_next;
   logic               w_next_event;

   // Clamp step and load value to the current limit; build the candidate results.
   // Wrapped results always land in 0..limit_i, so width_p-bit modular arithmetic
   // is exact for them even when limit_i is all-ones; only the overflow test
   // needs the extra bit.
   always_comb begin
      w_step_eff     = (bus.step_i > bus.limit_i) ? bus.limit_i : bus.step_i;
      w_load_eff     = (bus.load_val_i > bus.limit_i) ? bus.limit_i : bus.load_val_i;
      w_sum          = {1'b0, r_count} + {1'b0, w_step_eff};
      w_up_wrap      = r_count + w_step_eff - bus.limit_i - 1'b1;
      w_dn_wrap      = r_count + bus.limit_i + 1'b1 - w_step_eff;
      w_out_of_range = (r_count > bus.limit_i);
      w_move         = bus.up_i ^ bus.down_i;
   end

   // Next count and next event, in priority order reset > clear > load > move > hold.
   always_comb begin
      w_next       = r_count;
      w_next_event = 1'b0;
      if (reset_i) begin
         w_next = reset_val_p;
      end else if (bus.clear_i) begin
         w_next = '0;
      end else if (bus.load_i) begin
         w_next = w_load_eff;
      end else if (w_move) begin
         if (w_out_of_range) begin
            // A limit lowered under the count snaps it back into range.
            w_next       = saturate_p ? bus.limit_i : '0;
            w_next_event = 1'b1;
         end else if (w_step_eff != '0) begin
            if (bus.up_i) begin
               if (w_sum > {1'b0, bus.limit_i}) begin
                  w_next       = saturate_p ? bus.limit_i : w_up_wrap;
                  w_next_event = 1'b1;
               end else begin
                  w_next = w_sum[width_p-1:0];
               end
            end else begin
               if (w_step_eff > r_count) begin
                  w_next       = saturate_p ? '0 : w_dn_wrap;
                  w_next_event = 1'b1;
               end else begin
                  w_next = r_count - w_step_eff;
               end
            end
         end
      end
   end

   // Count and event registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_count <= reset_val_p;
         r_event <= 1'b0;
      end else begin
         r_count <= w_next;
         r_event <= w_next_event;
      end
   end

   assign bus.count_o   = r_count;
   assign bus.count_n_o = w_next;
   assign bus.at_max_o  = (r_count == bus.limit_i);
   assign bus.at_zero_o = (r_count == '0);
   assign bus.event_o   = r_event;

endmodule

// File: tb/tb_updown_step_counter.sv
// tb/tb_updown_step_counter.sv - self-checking bench for updown_step_counter
module tb_updown_step_counter;

   logic       clk;
   logic       rst;
   logic       clear, load, up, down;
   logic [7:0] lv, step, lim;

   int checks = 0;
   int errors = 0;

   // Instance 0: 4-bit wrap, reset value 2; 1: 4-bit saturate; 2: 8-bit wrap.
   int cfg_w  [3] = '{4, 4, 8};
   bit cfg_s  [3] = '{1'b0, 1'b1, 1'b0};
   int cfg_rv [3] = '{2, 0, 0};

   int m_cnt [3];
   bit m_ev  [3];

   logic [7:0] a_cnt [3];
   logic [7:0] a_nxt [3];
   logic       a_ev  [3];
   logic       a_max [3];
   logic       a_zero[3];

   updown_step_counter_if #(.width_p(4)) if_w ();
   updown_step_counter_if #(.width_p(4)) if_s ();
   updown_step_counter_if #(.width_p(8)) if_8 ();

   updown_step_counter #(.width_p(4), .reset_val_p(4'd2), .saturate_p(1'b0)) u_w (
      .clk_i(clk), .reset_i(rst), .bus(if_w.slave));
   updown_step_counter #(.width_p(4), .reset_val_p(4'd0), .saturate_p(1'b1)) u_s (
      .clk_i(clk), .reset_i(rst), .bus(if_s.slave));
   updown_step_counter #(.width_p(8), .reset_val_p(8'd0), .saturate_p(1'b0)) u_8 (
      .clk_i(clk), .reset_i(rst), .bus(if_8.slave));

   assign if_w.clear_i = clear; assign if_w.load_i = load; assign if_w.load_val_i = lv[3:0];
   assign if_w.up_i = up; assign if_w.down_i = down; assign if_w.step_i = step[3:0]; assign if_w.limit_i = lim[3:0];
   assign if_s.clear_i = clear; assign if_s.load_i = load; assign if_s.load_val_i = lv[3:0];
   assign if_s.up_i = up; assign if_s.down_i = down; assign if_s.step_i = step[3:0]; assign if_s.limit_i = lim[3:0];
   assign if_8.clear_i = clear; assign if_8.load_i = load; assign if_8.load_val_i = lv;
   assign if_8.up_i = up; assign if_8.down_i = down; assign if_8.step_i = step; assign if_8.limit_i = lim;

   assign a_cnt[0] = {4'd0, if_w.count_o};   assign a_nxt[0] = {4'd0, if_w.count_n_o};
   assign a_cnt[1] = {4'd0, if_s.count_o};   assign a_nxt[1] = {4'd0, if_s.count_n_o};
   assign a_cnt[2] = if_8.count_o;           assign a_nxt[2] = if_8.count_n_o;
   assign a_ev[0] = if_w.event_o;  assign a_max[0] = if_w.at_max_o;  assign a_zero[0] = if_w.at_zero_o;
   assign a_ev[1] = if_s.event_o;  assign a_max[1] = if_s.at_max_o;  assign a_zero[1] = if_s.at_zero_o;
   assign a_ev[2] = if_8.event_o;  assign a_max[2] = if_8.at_max_o;  assign a_zero[2] = if_8.at_zero_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       clr;
      logic       ld;
      logic [7:0] lv;
      logic       up;
      logic       dn;
      logic [7:0] st;
      logic [7:0] lim;
      logic [7:0] ew;
      logic       ew_ev;
      logic [7:0] es;
      logic       es_ev;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit c, input bit l, input int v, input bit u, input bit d,
                               input int s, input int m, input int ew, input bit ewe,
                               input int es, input bit ese);
      vec_t r;
      r.clr = c; r.ld = l; r.lv = 8'(v); r.up = u; r.dn = d; r.st = 8'(s); r.lim = 8'(m);
      r.ew = 8'(ew); r.ew_ev = ewe; r.es = 8'(es); r.es_ev = ese;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the rules, per instance configuration.
   function automatic void model(input int w, input bit sat, input int cnt,
                                 output int nxt, output bit ev);
      int mask = (1 << w) - 1;
      int l    = int'(lim) & mask;
      int v    = int'(lv) & mask;
      int s    = int'(step) & mask;
      nxt = cnt;
      ev  = 1'b0;
      if (s > l) s = l;
      if (clear) nxt = 0;
      else if (load) nxt = (v < l) ? v : l;
      else if (up != down) begin
         if (cnt > l) begin
            nxt = sat ? l : 0;
            ev  = 1'b1;
         end else if (s != 0) begin
            if (up) begin
               if (cnt + s > l) begin
                  nxt = sat ? l : cnt + s - (l + 1);
                  ev  = 1'b1;
               end else nxt = cnt + s;
            end else begin
               if (s > cnt) begin
                  nxt = sat ? 0 : cnt + (l + 1) - s;
                  ev  = 1'b1;
               end else nxt = cnt - s;
            end
         end
      end
   endfunction

   task automatic tick();
      int nx[3];
      bit ne[3];
      #2;
      for (int i = 0; i < 3; i++) begin
         model(cfg_w[i], cfg_s[i], m_cnt[i], nx[i], ne[i]);
         chk($sformatf("count_n_o[%0d]", i), int'(a_nxt[i]), nx[i]);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = nx[i];
         m_ev[i]  = ne[i];
         chk($sformatf("count_o[%0d]", i), int'(a_cnt[i]), m_cnt[i]);
         chk($sformatf("event_o[%0d]", i), int'(a_ev[i]), int'(m_ev[i]));
         chk($sformatf("at_max_o[%0d]", i), int'(a_max[i]),
             int'(m_cnt[i] == (int'(lim) & ((1 << cfg_w[i]) - 1))));
         chk($sformatf("at_zero_o[%0d]", i), int'(a_zero[i]), int'(m_cnt[i] == 0));
      end
   endtask

   task automatic set_in(input bit c, input bit l, input int v, input bit u, input bit d,
                         input int s, input int m);
      clear = c; load = l; lv = 8'(v); up = u; down = d; step = 8'(s); lim = 8'(m);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 9);
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = cfg_rv[i];
         m_ev[i]  = 1'b0;
      end
      #1;
      chk("reset count_o w", int'(a_cnt[0]), 2);
      chk("reset count_n_o w", int'(a_nxt[0]), 2);
      chk("reset count_o s", int'(a_cnt[1]), 0);
      chk("reset event_o w", int'(a_ev[0]), 0);
      chk("reset count_o 8", int'(a_cnt[2]), 0);
      @(negedge clk);
      rst = 1'b0;

      //          clr ld lv up dn st lim   ew ev  es ev
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 9,   0, 0,  0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 9,   3, 0,  3, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 9,   6, 0,  6, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 9,   9, 0,  9, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 9,   2, 1,  9, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 9,   5, 0,  9, 1));
      tbl.push_back(mk(0, 1, 2, 0, 0, 0, 9,   2, 0,  2, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 4, 9,   8, 1,  0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 4, 9,   8, 0,  0, 0));
      tbl.push_back(mk(0, 1, 10, 0, 0, 0, 12, 10, 0, 10, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 5, 12,  2, 1, 12, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 5, 12,  7, 0, 12, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 5, 12,  2, 0,  7, 0));
      tbl.push_back(mk(1, 1, 7, 1, 0, 3, 9,   0, 0,  0, 0));
      tbl.push_back(mk(0, 1, 15, 0, 0, 0, 9,  9, 0,  9, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 3, 9,   9, 0,  9, 0));
      tbl.push_back(mk(0, 1, 8, 0, 0, 0, 9,   8, 0,  8, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 3,   0, 1,  3, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 9,   1, 0,  1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 6, 3,   0, 1,  3, 1));
      tbl.push_back(mk(0, 1, 15, 0, 0, 0, 15, 15, 0, 15, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 15,  0, 1, 15, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 15, 15, 1, 14, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 9,   0, 0,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 9,   0, 0,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 2, 9,   8, 1,  0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 2, 0,   0, 1,  0, 0));

      foreach (tbl[k]) begin
         set_in(tbl[k].clr, tbl[k].ld, int'(tbl[k].lv), tbl[k].up, tbl[k].dn,
                int'(tbl[k].st), int'(tbl[k].lim));
         tick();
         chk($sformatf("vec%0d wrap count", k), int'(a_cnt[0]), int'(tbl[k].ew));
         chk($sformatf("vec%0d wrap event", k), int'(a_ev[0]), int'(tbl[k].ew_ev));
         chk($sformatf("vec%0d sat count", k), int'(a_cnt[1]), int'(tbl[k].es));
         chk($sformatf("vec%0d sat event", k), int'(a_ev[1]), int'(tbl[k].es_ev));
      end

      // limit 0 with count 0 raises both flags
      chk("lim0 at_max w", int'(a_max[0]), 1);
      chk("lim0 at_zero w", int'(a_zero[0]), 1);
      chk("lim0 at_max s", int'(a_max[1]), 1);
      chk("lim0 at_zero s", int'(a_zero[1]), 1);

      // async reset mid-count with an event pending
      set_in(0, 1, 9, 0, 0, 0, 9);
      tick();
      set_in(0, 0, 0, 1, 0, 6, 9);
      tick();
      chk("pre-reset count w", int'(a_cnt[0]), 5);
      chk("pre-reset event w", int'(a_ev[0]), 1);
      set_in(0, 0, 0, 0, 0, 0, 9);
      #2;
      rst = 1'b1;
      #1;
      chk("async reset count w", int'(a_cnt[0]), 2);
      chk("async reset event w", int'(a_ev[0]), 0);
      chk("async reset count_n w", int'(a_nxt[0]), 2);
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = cfg_rv[i];
         m_ev[i]  = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("reset held count w", int'(a_cnt[0]), 2);
      @(negedge clk);
      rst = 1'b0;

      // full-range limit wraps 255 -> 0 on the 8-bit instance
      set_in(0, 1, 255, 0, 0, 1, 255);
      tick();
      set_in(0, 0, 0, 1, 0, 1, 255);
      tick();
      chk("w8 wrap count", int'(a_cnt[2]), 0);
      chk("w8 wrap event", int'(a_ev[2]), 1);

      // randomized traffic against the reference model
      for (int n = 0; n < 500; n++) begin
         clear = ($urandom_range(0, 31) == 0);
         load  = ($urandom_range(0, 15) == 0);
         lv    = 8'($urandom_range(0, 255));
         up    = 1'($urandom_range(0, 1));
         down  = 1'($urandom_range(0, 1));
         step  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
         if ($urandom_range(0, 7) == 0)
            lim = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
